// File: rtl/wled_update_ctrl_pkg.sv
// Shared definitions for the LED update sequencer: op codes, colour order
// encodings, FSM states and the per-channel brightness scale helper.
package wled_pkg;

  typedef enum logic [1:0] {
    OP_SET   = 2'd0,
    OP_FILL  = 2'd1,
    OP_CLEAR = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  localparam int ORDER_GRB = 0;
  localparam int ORDER_RGB = 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SET  = 2'd1,
    S_FILL = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // out = (c * (b + 1)) >> 8; the product never exceeds 16 bits
  function automatic logic [7:0] scale_chan(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] p;
    p = {8'd0, c} * ({8'd0, b} + 16'd1);
    return p[15:8];
  endfunction

endpackage

// File: rtl/wled_update_ctrl_if.sv
// Host command handshake for the LED update sequencer.
interface wled_update_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [7:0]  req_led;
  logic [23:0] req_rgb;
  logic [7:0]  brightness;

  modport master (
    output req_valid, req_op, req_led, req_rgb, brightness,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_op, req_led, req_rgb, brightness,
    output req_ready
  );
endinterface

// File: rtl/wled_color_scale.sv
// Combinational brightness scaling and channel reorder of an R,G,B colour.
module wled_color_scale
  import wled_pkg::*;
#(
  parameter int COLOR_ORDER = ORDER_GRB
) (
  input  logic [23:0] rgb_i,
  input  logic [7:0]  brightness_i,
  output logic [23:0] color_o
);

  logic [7:0] r_s, g_s, b_s;

  // scale each channel, then pack in the driver's expected order
  always_comb begin
    r_s = scale_chan(rgb_i[23:16], brightness_i);
    g_s = scale_chan(rgb_i[15:8],  brightness_i);
    b_s = scale_chan(rgb_i[7:0],   brightness_i);
    if (COLOR_ORDER == ORDER_RGB) color_o = {r_s, g_s, b_s};
    else                          color_o = {g_s, r_s, b_s};
  end

endmodule

// File: rtl/wled_update_ctrl.sv
// Command sequencer feeding the ws2812 driver frame buffer write port.
module wled_update_ctrl
  import wled_pkg::*;
#(
  parameter int NUM_LEDS    = 1,
  parameter int COLOR_ORDER = ORDER_GRB
) (
  input  logic               clk,
  input  logic               rst,
  wled_update_ctrl_if.slave  req,
  output logic [23:0]        rgb_data,
  output logic [7:0]         led_num,
  output logic               write,
  output logic               done,
  output logic               err
);

  localparam logic [8:0] NUM_LEDS_W = 9'(NUM_LEDS);
  localparam logic [7:0] LAST_IDX   = 8'(NUM_LEDS - 1);

  state_e      state_q;
  logic        ready_q, write_q, done_q, err_q;
  logic [23:0] rgb_q, color_q, scaled, new_color;
  logic [7:0]  led_q, idx_q;
  logic        accept, led_ok;

  wled_color_scale #(.COLOR_ORDER(COLOR_ORDER)) u_scale (
    .rgb_i        (req.req_rgb),
    .brightness_i (req.brightness),
    .color_o      (scaled)
  );

  // accept qualification and colour captured for the command
  always_comb begin
    accept    = req.req_valid && ready_q;
    led_ok    = {1'b0, req.req_led} < NUM_LEDS_W;
    new_color = (op_e'(req.req_op) == OP_CLEAR) ? '0 : scaled;
  end

  // Sequencer FSM. The first write of SET/FILL is registered on the accept
  // edge so it appears at T+1 while the FSM sits in SET/FILL.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ready_q <= 1'b0;
      write_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rgb_q   <= '0;
      led_q   <= '0;
      idx_q   <= '0;
      color_q <= '0;
    end else begin
      write_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          ready_q <= !accept;
          if (accept) begin
            color_q <= new_color;
            case (op_e'(req.req_op))
              OP_SET: begin
                if (led_ok) begin
                  state_q <= S_SET;
                  write_q <= 1'b1;
                  led_q   <= req.req_led;
                  rgb_q   <= new_color;
                end else begin
                  state_q <= S_DONE;
                  err_q   <= 1'b1;
                  done_q  <= 1'b1;
                end
              end
              OP_FILL, OP_CLEAR: begin
                state_q <= S_FILL;
                idx_q   <= '0;
                write_q <= 1'b1;
                led_q   <= '0;
                rgb_q   <= new_color;
              end
              default: begin
                state_q <= S_DONE;
                err_q   <= 1'b1;
                done_q  <= 1'b1;
              end
            endcase
          end
        end
        S_SET: begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
        end
        S_FILL: begin
          if (idx_q == LAST_IDX) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            idx_q   <= idx_q + 8'd1;
            write_q <= 1'b1;
            led_q   <= idx_q + 8'd1;
            rgb_q   <= color_q;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req.req_ready = ready_q;
  assign rgb_data      = rgb_q;
  assign led_num       = led_q;
  assign write         = write_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule
